// File: rtl/instr_encoder.sv
// instr_encoder: packs mnemonic + fields into MIPS words, buffers them in a FIFO
// and streams them out with sequential, wrapping instruction-memory byte addresses.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          IM_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    input  logic        finish,
    input  logic        start,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic [15:0] word_count,
    output logic        done,
    output logic        wrap_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (IM_WORDS - 1));

    typedef enum logic [1:0] {LOAD, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d, last_q, last_d;
    logic [15:0]   wc_q, wc_d;
    logic          wrap_q, wrap_d;
    logic [31:0]   enc;
    logic          empty, full, push, pop;

    always_comb begin
        enc = '0;
        case (in_op)
            4'd1:    enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'h21};
            4'd2:    enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'h23};
            4'd3:    enc = {6'd0, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
            4'd4:    enc = {6'd0, 5'd0, in_rt, in_rd, in_shamt, 6'h02};
            4'd5:    enc = {6'd0, 5'd0, in_rt, in_rd, in_shamt, 6'h03};
            4'd6:    enc = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'h2a};
            4'd7:    enc = {6'd0, in_rs, 5'd0, in_rd, 5'd0, 6'h09};
            4'd8:    enc = {6'd0, in_rs, 15'd0, 6'h08};
            4'd9:    enc = {6'h0d, in_rs, in_rt, in_imm};
            4'd10:   enc = {6'h23, in_rs, in_rt, in_imm};
            4'd11:   enc = {6'h2b, in_rs, in_rt, in_imm};
            4'd12:   enc = {6'h04, in_rs, in_rt, in_imm};
            4'd13:   enc = {6'h0f, 5'd0, in_rt, in_imm};
            4'd14:   enc = {6'h02, in_target};
            4'd15:   enc = {6'h03, in_target};
            default: enc = '0;
        endcase
    end

    assign empty      = count_q == '0;
    assign full       = count_q == CW'(DEPTH);
    assign in_ready   = state_q == LOAD && !full;
    assign out_valid  = !empty && state_q != DONE;
    // With nothing queued the output keeps showing the last word handed off
    assign out_data   = empty ? last_q : mem_q[rd_ptr_q];
    assign out_addr   = addr_q;
    assign word_count = wc_q;
    assign done       = state_q == DONE;
    assign wrap_err   = wrap_q;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
        addr_d   = !pop ? addr_q : addr_q == LAST_ADDR ? BASE_ADDR : addr_q + 32'd4;
        wrap_d   = wrap_q || (pop && addr_q == LAST_ADDR);
        wc_d     = pop ? wc_q + 16'd1 : wc_q;
        state_d  = state_q;
        if (push) mem_d[wr_ptr_q] = enc;
        case (state_q)
            LOAD:    state_d = !finish ? LOAD : (empty && !push) ? DONE : DRAIN;
            DRAIN:   state_d = empty ? DONE : DRAIN;
            default: state_d = start ? LOAD : DONE;
        endcase
        if (state_q == DONE && start) begin
            addr_d = BASE_ADDR;
            wc_d   = '0;
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            last_q   <= '0;
            wc_q     <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            wc_q     <= wc_d;
            wrap_q   <= wrap_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus with a queue-based reference model checked every
// cycle, plus hand-computed literal expectations.
module tb_instr_encoder;
    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam logic [31:0] LAST = BASE + 32'd12;

    logic clk = 0, reset = 1;
    logic in_valid = 0, in_ready, finish = 0, start = 0, out_valid, out_ready = 0, done, wrap_err;
    logic [3:0] in_op = 0;
    logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
    logic [15:0] in_imm = 0, word_count;
    logic [25:0] in_target = 0;
    logic [31:0] out_data, out_addr;

    int checks = 0, failures = 0;

    instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE), .IM_WORDS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_target(in_target), .finish(finish), .start(start), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .word_count(word_count), .done(done), .wrap_err(wrap_err)
    );

    always #5 clk = ~clk;

    int opc_t[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 35, 43, 4, 15, 2, 3};
    int fn_t[16]  = '{0, 33, 35, 0, 2, 3, 42, 9, 8, 0, 0, 0, 0, 0, 0, 0};

    function automatic logic [31:0] model_enc(int op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                              logic [4:0] sh, logic [15:0] imm, logic [25:0] tg);
        int w;
        if (op == 0) return 32'h0;
        if (op >= 14) return 32'(opc_t[op] * 67108864 + int'(tg));
        if (op >= 9) return (32'(opc_t[op]) << 26) | (32'(op == 13 ? 5'd0 : rs) << 21)
                            | (32'(rt) << 16) | 32'(imm);
        w = fn_t[op];
        if (op inside {1, 2, 6, 7, 8}) w += int'(rs) * 2097152;
        if (op inside {1, 2, 3, 4, 5, 6}) w += int'(rt) * 65536;
        if (op inside {1, 2, 3, 4, 5, 6, 7}) w += int'(rd) * 2048;
        if (op inside {3, 4, 5}) w += int'(sh) * 64;
        return 32'(w);
    endfunction

    logic [31:0] q[$];
    logic [31:0] m_addr, m_last;
    logic [15:0] m_wc;
    bit m_wrap, live = 0, m_rdy, m_vld, m_pu, m_po;
    int ph, n;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            ph = 0; m_addr = BASE; m_wc = 0; m_wrap = 0; m_last = 0; live = 1;
        end else if (live) begin
            n = q.size();
            m_rdy = ph == 0 && n < 4;
            m_vld = n > 0 && ph != 2;
            m_pu = in_valid && m_rdy;
            m_po = m_vld && out_ready;
            if (m_po) begin
                m_last = q.pop_front();
                if (m_addr == LAST) begin m_addr = BASE; m_wrap = 1; end
                else m_addr = m_addr + 4;
                m_wc = m_wc + 1;
            end
            if (m_pu) q.push_back(model_enc(int'(in_op), in_rs, in_rt, in_rd, in_shamt, in_imm, in_target));
            if (ph == 0 && finish) ph = (n == 0 && !m_pu) ? 2 : 1;
            else if (ph == 1 && n == 0) ph = 2;
            else if (ph == 2 && start) begin ph = 0; m_addr = BASE; m_wc = 0; m_wrap = 0; end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    always @(negedge clk) if (live) begin
        chk("m_in_ready", 32'(in_ready), 32'(ph == 0 && q.size() < 4));
        chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0 && ph != 2));
        chk("m_out_data", out_data, q.size() > 0 ? q[0] : m_last);
        chk("m_out_addr", out_addr, m_addr);
        chk("m_word_count", 32'(word_count), 32'(m_wc));
        chk("m_done", 32'(done), 32'(ph == 2));
        chk("m_wrap_err", 32'(wrap_err), 32'(m_wrap));
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tg);
        bit hs = 0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm; in_target = tg;
        in_valid = 1;
        for (int i = 0; i < 40 && !hs; i++) begin
            hs = in_ready;
            step();
        end
        in_valid = 0;
        if (!hs) chk("push_timeout", 0, 1);
    endtask

    task automatic pop_one();
        out_ready = 1; step(); out_ready = 0;
    endtask

    task automatic pulse_finish();
        finish = 1; step(); finish = 0;
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 32'h3000);
        chk("rst_word_count", 32'(word_count), 0);
        chk("rst_done_wrap", {30'd0, done, wrap_err}, 0);

        push(4'd1, 5'd1, 5'd2, 5'd3, 5'd7, 16'hffff, 26'h3ffffff);
        chk("addu_valid", 32'(out_valid), 1);
        chk("addu_data", out_data, 32'h00221821);
        chk("addu_addr", out_addr, 32'h3000);
        push(4'd3, 5'd9, 5'd2, 5'd3, 5'd4, 16'hbeef, 26'h1234567);
        push(4'd9, 5'd0, 5'd1, 5'd31, 5'd31, 16'h1234, 26'h3ffffff);
        pop_one();
        chk("sll_data", out_data, 32'h00021900);
        chk("sll_addr", out_addr, 32'h3004);
        pop_one();
        chk("ori_data", out_data, 32'h34011234);
        chk("ori_addr", out_addr, 32'h3008);
        pop_one();
        chk("empty_valid", 32'(out_valid), 0);
        chk("empty_hold", out_data, 32'h34011234);
        chk("wc3", 32'(word_count), 3);
        push(4'd10, 5'd1, 5'd2, 5'd9, 5'd9, 16'h0004, 26'h2aaaaaa);
        push(4'd15, 5'd7, 5'd7, 5'd7, 5'd7, 16'h7777, 26'h000C00);
        chk("lw_data", out_data, 32'h8C220004);
        chk("lw_addr", out_addr, 32'h300C);
        chk("lw_wrap", 32'(wrap_err), 0);
        pop_one();
        chk("jal_data", out_data, 32'h0C000C00);
        chk("jal_addr_wrapped", out_addr, 32'h3000);
        chk("jal_wrap", 32'(wrap_err), 1);
        pop_one();
        chk("wc5", 32'(word_count), 5);

        pulse_start();
        chk("start_ignored_wc", 32'(word_count), 5);
        pulse_finish();
        chk("done_direct", 32'(done), 1);
        chk("done_in_ready", 32'(in_ready), 0);
        pulse_start();
        chk("restart_done", 32'(done), 0);
        chk("restart_addr", out_addr, 32'h3000);
        chk("restart_wc", 32'(word_count), 0);
        chk("restart_wrap", 32'(wrap_err), 0);

        push(4'd2, 5'd4, 5'd5, 5'd6, 5'd1, 16'h1111, 26'h1);
        push(4'd4, 5'd1, 5'd2, 5'd3, 5'd5, 16'h2222, 26'h2);
        push(4'd5, 5'd3, 5'd4, 5'd5, 5'd6, 16'h3333, 26'h3);
        push(4'd6, 5'd7, 5'd8, 5'd9, 5'd2, 16'h4444, 26'h4);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_head", out_data, 32'h00853023);
        step();
        chk("full_hold", 32'(in_ready), 0);
        out_ready = 1;
        push(4'd7, 5'd10, 5'd11, 5'd12, 5'd13, 16'h5555, 26'h5);
        repeat (6) step();
        chk("drained_wc", 32'(word_count), 5);

        for (int op = 0; op < 16; op++)
            push(4'(op), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
        repeat (5) step();
        out_ready = 0;

        push(4'd12, 5'd3, 5'd4, 5'd0, 5'd0, 16'hfffe, 26'h0);
        push(4'd13, 5'd5, 5'd6, 5'd7, 5'd8, 16'habcd, 26'h0);
        pulse_finish();
        chk("drain_not_done", 32'(done), 0);
        chk("drain_in_ready", 32'(in_ready), 0);
        out_ready = 1;
        for (int i = 0; i < 20 && !done; i++) step();
        chk("drain_done", 32'(done), 1);
        out_ready = 0;
        pulse_start();

        for (int i = 0; i < 4; i++) push(4'd11, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(i * 8), 26'h0);
        pop_one();
        chk("pre_reset_wc", 32'(word_count), 1);
        reset = 1; step(); reset = 0;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_addr", out_addr, 32'h3000);
        chk("mid_rst_wc", 32'(word_count), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
